uart_data_sender: RTL and testbench

//  Transmit side of the 784-element binary image link. Reads a 784-entry array of
//  32-bit signed elements over an address/data port and packs 8 elements per byte
//  (element byte*8+i -> bit i). Sends 98 bytes over UART 8N1, LSB first, using an

---
 rtl/uart_data_sender_if.sv | 32 +++
 rtl/uart_data_sender.sv | 154 +++++++++++++++
 tb/tb_uart_data_sender.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_data_sender_if.sv
// Frame-sender bus: start request, element read port, UART line and status.
interface uart_data_sender_if;
   logic        start;
   logic [9:0]  data_addr;
   logic [31:0] data_element;
   logic        tx_serial;
   logic        active;
   logic        done;
   logic [2:0]  led;

   // Sender side: drives address, line and status; consumes start and element data.
   modport master (
      input  start,
      input  data_element,
      output data_addr,
      output tx_serial,
      output active,
      output done,
      output led
   );

   // Host/memory side.
   modport slave (
      output start,
      output data_element,
      input  data_addr,
      input  tx_serial,
      input  active,
      input  done,
      input  led
   );
endinterface

// File: rtl/uart_data_sender.sv
// Packs a binary image (8 elements per byte, element byte*8+i -> bit i) and sends it
// over UART 8N1, LSB first. Any nonzero element maps to a 1 bit.
module uart_data_sender #(
   parameter int unsigned CLKS_PER_BIT = 5209,
   parameter int unsigned NUM_ELEMENTS = 784
) (
   input logic                 i_Clock,
   input logic                 i_Rst,
   uart_data_sender_if.master  bus
);

   localparam int unsigned NumBytes = (NUM_ELEMENTS + 7) / 8;
   localparam int unsigned ByteW    = (NumBytes > 1) ? $clog2(NumBytes) : 1;
   localparam int unsigned BaudW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [ByteW-1:0] ByteLast = ByteW'(NumBytes - 1);
   localparam logic [15:0]      NumElem  = 16'(NUM_ELEMENTS);

   typedef enum logic [2:0] {
      StIdle, StLoad, StStart, StData, StStop, StDone
   } state_e;

   state_e           state_q;
   logic [ByteW-1:0] byte_cnt_q;
   logic [2:0]       bit_idx_q;
   logic [3:0]       load_cnt_q;
   logic [BaudW-1:0] baud_cnt_q;
   logic [7:0]       shift_q;
   logic [9:0]       addr_q;
   logic             tx_q;
   logic             active_q;
   logic             done_q;
   logic [2:0]       led_q;

   logic [15:0] base_idx;
   logic [15:0] issue_idx;
   logic [15:0] cap_idx;
   logic [9:0]  next_base;
   logic        elem_bit;
   logic        baud_wrap;

   // Element indices for the current LOAD cycle: the address to issue next and the
   // element whose data is arriving this cycle (one-cycle read latency).
   always_comb begin
      base_idx  = 16'(byte_cnt_q) << 3;
      issue_idx = base_idx + 16'(load_cnt_q) + 16'd1;
      cap_idx   = base_idx + 16'(load_cnt_q) - 16'd1;
      next_base = 10'((32'(byte_cnt_q) + 32'd1) * 32'd8);
      // Elements past the end of the frame were never addressed and pack as 0.
      elem_bit  = (bus.data_element != 32'd0) && (cap_idx < NumElem);
      baud_wrap = (baud_cnt_q == BaudLast);
   end

   // Frame sequencer, packer and serializer with registered outputs.
   always_ff @(posedge i_Clock) begin
      if (i_Rst) begin
         state_q    <= StIdle;
         byte_cnt_q <= '0;
         bit_idx_q  <= '0;
         load_cnt_q <= '0;
         baud_cnt_q <= '0;
         shift_q    <= '0;
         addr_q     <= '0;
         tx_q       <= 1'b1;
         active_q   <= 1'b0;
         done_q     <= 1'b0;
         led_q      <= 3'b001;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               tx_q       <= 1'b1;
               addr_q     <= '0;
               baud_cnt_q <= '0;
               if (bus.start) begin
                  state_q    <= StLoad;
                  byte_cnt_q <= '0;
                  load_cnt_q <= '0;
                  active_q   <= 1'b1;
                  led_q      <= 3'b010;
               end
            end
            StLoad: begin
               if (load_cnt_q != 4'd0) begin
                  shift_q[3'(load_cnt_q - 4'd1)] <= elem_bit;
               end
               if ((load_cnt_q < 4'd7) && (issue_idx < NumElem)) begin
                  addr_q <= issue_idx[9:0];
               end
               if (load_cnt_q == 4'd8) begin
                  state_q    <= StStart;
                  tx_q       <= 1'b0;
                  baud_cnt_q <= '0;
                  led_q      <= 3'b100;
               end else begin
                  load_cnt_q <= load_cnt_q + 4'd1;
               end
            end
            StStart: begin
               baud_cnt_q <= baud_wrap ? '0 : baud_cnt_q + 1'b1;
               if (baud_wrap) begin
                  state_q   <= StData;
                  bit_idx_q <= '0;
                  tx_q      <= shift_q[0];
               end
            end
            StData: begin
               baud_cnt_q <= baud_wrap ? '0 : baud_cnt_q + 1'b1;
               if (baud_wrap) begin
                  if (bit_idx_q == 3'd7) begin
                     state_q <= StStop;
                     tx_q    <= 1'b1;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                     tx_q      <= shift_q[bit_idx_q + 3'd1];
                  end
               end
            end
            StStop: begin
               baud_cnt_q <= baud_wrap ? '0 : baud_cnt_q + 1'b1;
               if (baud_wrap) begin
                  if (byte_cnt_q == ByteLast) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end else begin
                     byte_cnt_q <= byte_cnt_q + 1'b1;
                     load_cnt_q <= '0;
                     addr_q     <= next_base;
                     state_q    <= StLoad;
                     led_q      <= 3'b010;
                  end
               end
            end
            StDone: begin
               active_q <= 1'b0;
               state_q  <= StIdle;
               led_q    <= 3'b001;
            end
            default: begin
               state_q <= StIdle;
               tx_q    <= 1'b1;
               led_q   <= 3'b001;
            end
         endcase
      end
   end

   assign bus.data_addr = addr_q;
   assign bus.tx_serial = tx_q;
   assign bus.active    = active_q;
   assign bus.done      = done_q;
   assign bus.led       = led_q;

endmodule

// File: tb/tb_uart_data_sender.sv
// Scoreboard bench: expected bytes are queued when a frame is requested and
// compared as the UART monitor decodes the line.
module tb_uart_data_sender;

   localparam int unsigned CPB = 4;
   localparam int unsigned NE  = 784;
   localparam int unsigned NB  = 98;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int unsigned cyc = 0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_data_sender_if bus ();

   uart_data_sender #(
      .CLKS_PER_BIT (CPB),
      .NUM_ELEMENTS (NE)
   ) dut (
      .i_Clock (clk),
      .i_Rst   (rst),
      .bus     (bus)
   );

   // Element memory with one-cycle read latency.
   logic [31:0] mem [NE];
   always @(posedge clk) begin
      bus.data_element <= (bus.data_addr < 10'(NE)) ? mem[bus.data_addr] : 32'd0;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   logic [7:0] exp_q [$];
   int rx_count = 0;

   // UART monitor: samples mid-bit, abandons a byte cut short by reset.
   initial begin : uart_mon
      bit busy;
      int cnt;
      int k;
      logic [7:0] data;
      busy = 0;
      cnt  = 0;
      data = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy = 0;
         end else begin
            if (!busy && bus.tx_serial == 1'b0) begin
               busy = 1;
               cnt  = 0;
            end else if (busy) begin
               cnt++;
            end
            if (busy && (cnt % CPB) == CPB / 2) begin
               k = cnt / CPB;
               if (k == 0) begin
                  check_eq("start_bit", 32'(bus.tx_serial), 32'd0);
               end else if (k <= 8) begin
                  data[k-1] = bus.tx_serial;
               end else begin
                  check_eq("stop_bit", 32'(bus.tx_serial), 32'd1);
                  check_eq("sb_pending", 32'(exp_q.size() != 0), 32'd1);
                  if (exp_q.size() != 0) begin
                     check_eq($sformatf("byte%0d", rx_count), 32'(data), 32'(exp_q.pop_front()));
                  end
                  rx_count++;
                  busy = 0;
               end
            end
         end
      end
   end

   int done_pulses = 0;
   int done_wide   = 0;
   bit log_en      = 0;
   logic [9:0] addr_log [$];

   // Done pulse counting/width and LOAD address capture.
   initial begin : status_mon
      logic done_prev;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.done && !done_prev) done_pulses++;
         if (bus.done && done_prev) done_wide++;
         done_prev = bus.done;
         if (log_en && bus.led == 3'b010 && addr_log.size() < 18) begin
            addr_log.push_back(bus.data_addr);
         end
      end
   end

   task automatic push_frame();
      for (int b = 0; b < int'(NB); b++) begin
         logic [7:0] v;
         v = '0;
         for (int i = 0; i < 8; i++) begin
            if (b * 8 + i < int'(NE)) v[i] = (mem[b * 8 + i] != 32'd0);
         end
         exp_q.push_back(v);
      end
   endtask

   task automatic pulse_start(output int unsigned edge_cyc);
      @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 edge_cyc = cyc;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int max, output int unsigned at, output bit ok);
      ok = 0;
      at = 0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (bus.done) begin
            ok = 1;
            at = cyc;
            break;
         end
      end
   endtask

   task automatic wait_bytes(input int n, input int base, input int max);
      bit ok;
      ok = 0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (rx_count - base >= n) begin
            ok = 1;
            break;
         end
      end
      check_eq("wait_bytes", 32'(ok), 32'd1);
   endtask

   task automatic wait_led(input logic [2:0] v, input int max);
      bit ok;
      ok = 0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (bus.led == v) begin
            ok = 1;
            break;
         end
      end
      check_eq("wait_led", 32'(ok), 32'd1);
   endtask

   initial begin : main
      int unsigned e0;
      int unsigned at;
      bit ok;
      int base;
      int dp;

      bus.start = 1'b0;
      for (int i = 0; i < int'(NE); i++) mem[i] = 32'd0;

      // Reset held three cycles.
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_tx", 32'(bus.tx_serial), 32'd1);
      check_eq("rst_active", 32'(bus.active), 32'd0);
      check_eq("rst_done", 32'(bus.done), 32'd0);
      check_eq("rst_addr", 32'(bus.data_addr), 32'd0);
      check_eq("rst_led", 32'(bus.led), 32'd1);
      rst = 1'b0;

      // Frame A: sparse ones, latency and address sequence.
      mem[0] = 32'd1;
      mem[9] = 32'd1;
      mem[783] = 32'd1;
      log_en = 1;
      base = rx_count;
      dp = done_pulses;
      push_frame();
      pulse_start(e0);
      check_eq("a_active", 32'(bus.active), 32'd1);
      check_eq("a_led_load", 32'(bus.led), 32'd2);
      wait_done(6000, at, ok);
      check_eq("a_done_seen", 32'(ok), 32'd1);
      check_eq("a_done_latency", at - e0, 32'd4802);
      @(negedge clk);
      check_eq("a_done_width", 32'(bus.done), 32'd0);
      check_eq("a_active_off", 32'(bus.active), 32'd0);
      check_eq("a_led_idle", 32'(bus.led), 32'd1);
      check_eq("a_bytes", 32'(rx_count - base), 32'(NB));
      check_eq("a_sb_empty", 32'(exp_q.size()), 32'd0);
      check_eq("a_done_count", 32'(done_pulses - dp), 32'd1);
      log_en = 0;
      check_eq("a_addr_log_len", 32'(addr_log.size()), 32'd18);
      if (addr_log.size() == 18) begin
         for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("addr_l1_%0d", i), 32'(addr_log[i]), 32'(i));
            check_eq($sformatf("addr_l2_%0d", i), 32'(addr_log[9 + i]), 32'(8 + i));
         end
      end

      // Frame B: nonzero mapping plus an ignored mid-frame start.
      for (int i = 0; i < int'(NE); i++) mem[i] = 32'd0;
      mem[1] = 32'hFFFF_FFFF;
      mem[2] = 32'h2;
      base = rx_count;
      dp = done_pulses;
      push_frame();
      pulse_start(e0);
      wait_bytes(40, base, 3000);
      @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_done(6000, at, ok);
      check_eq("b_done_seen", 32'(ok), 32'd1);
      check_eq("b_done_latency", at - e0, 32'd4802);
      repeat (200) @(negedge clk);
      check_eq("b_bytes", 32'(rx_count - base), 32'(NB));
      check_eq("b_done_count", 32'(done_pulses - dp), 32'd1);
      check_eq("b_idle_active", 32'(bus.active), 32'd0);
      check_eq("b_sb_empty", 32'(exp_q.size()), 32'd0);

      // Frame C: reset during DATA of byte 50, then a clean frame.
      for (int i = 0; i < int'(NE); i++) begin
         mem[i] = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
      end
      mem[5] = 32'h8000_0000;
      base = rx_count;
      dp = done_pulses;
      push_frame();
      pulse_start(e0);
      wait_bytes(50, base, 3000);
      wait_led(3'b010, 100);
      wait_led(3'b100, 100);
      repeat (8) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      check_eq("c_rst_tx", 32'(bus.tx_serial), 32'd1);
      check_eq("c_rst_active", 32'(bus.active), 32'd0);
      check_eq("c_rst_led", 32'(bus.led), 32'd1);
      check_eq("c_bytes_before", 32'(rx_count - base), 32'd50);
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      base = rx_count;
      push_frame();
      pulse_start(e0);
      wait_done(6000, at, ok);
      check_eq("c_done_seen", 32'(ok), 32'd1);
      check_eq("c_done_latency", at - e0, 32'd4802);
      @(negedge clk);
      check_eq("c_bytes", 32'(rx_count - base), 32'(NB));
      check_eq("c_sb_empty", 32'(exp_q.size()), 32'd0);
      check_eq("c_done_count", 32'(done_pulses - dp), 32'd1);
      check_eq("done_never_wide", 32'(done_wide), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
